uibi_timer: RTL and testbench

- UIBI slave implementing a 64-bit machine timer (mtime/mtimecmp) plus a timer-interrupt output.
- Sits on the UIBI bus downstream of the cpu master; its intr output feeds back into the cpu interrupt input.
- Provides the platform's periodic tick and a free-running cycle counter readable by software.

---
 rtl/uibi_pkg.sv | 36 +++
 rtl/uibi_slave_if.sv | 92 +++++++++
 rtl/uibi_timer.sv | 176 +++++++++++++++++
 tb/tb_uibi_timer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uibi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uibi_pkg
// Shared UIBI definitions: access modes, handshake states, timer register map.
// Revision: 1.0
// ----------------------------------------------------------------------------
package uibi_pkg;

   localparam logic [2:0] MODE_B  = 3'b000;
   localparam logic [2:0] MODE_H  = 3'b001;
   localparam logic [2:0] MODE_W  = 3'b010;
   localparam logic [2:0] MODE_BU = 3'b100;
   localparam logic [2:0] MODE_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RESP     = 2'd1,
      WAIT_REL = 2'd2
   } bus_state_e;

   localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
   localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] OFF_CTRL        = 3'd4;
   localparam logic [2:0] OFF_PRESC       = 3'd5;

   localparam int CTRL_EN_BIT = 0;
   localparam int CTRL_IE_BIT = 1;

   function automatic logic is_word(input logic [2:0] mode);
      return mode == MODE_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uibi_slave_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uibi_slave_if
// Three-state UIBI slave handshake (IDLE/RESP/WAIT_REL) with request capture.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uibi_slave_if
   import uibi_pkg::*;
#(
   parameter int               XLEN   = 32,
   parameter int               NUM_W  = 4,
   parameter logic [NUM_W-1:0] DEV_ID = 4'd1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bus_req,
   input  logic             bus_wen,
   input  logic [2:0]       bus_mode,
   input  logic [XLEN-1:0]  bus_addr,
   input  logic [NUM_W-1:0] bus_num,
   input  logic [XLEN-1:0]  bus_dat_w,
   output logic             bus_ready,
   output logic             acc_en,
   output logic             acc_wen,
   output logic [2:0]       acc_mode,
   output logic [XLEN-1:0]  acc_addr,
   output logic [XLEN-1:0]  acc_dat
);

   bus_state_e      state_q, state_d;
   logic            cap_wen_q, cap_wen_d;
   logic [2:0]      cap_mode_q, cap_mode_d;
   logic [XLEN-1:0] cap_addr_q, cap_addr_d;
   logic [XLEN-1:0] cap_dat_q, cap_dat_d;
   logic            ready_q, ready_d;

   always_comb begin
      state_d    = state_q;
      cap_wen_d  = cap_wen_q;
      cap_mode_d = cap_mode_q;
      cap_addr_d = cap_addr_q;
      cap_dat_d  = cap_dat_q;
      ready_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus_req && (bus_num == DEV_ID)) begin
               cap_wen_d  = bus_wen;
               cap_mode_d = bus_mode;
               cap_addr_d = bus_addr;
               cap_dat_d  = bus_dat_w;
               state_d    = RESP;
            end
         end
         RESP: begin
            ready_d = 1'b1;
            state_d = WAIT_REL;
         end
         WAIT_REL: begin
            // A held request must be released before it can be served again.
            if (!bus_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cap_wen_q  <= 1'b0;
         cap_mode_q <= 3'd0;
         cap_addr_q <= '0;
         cap_dat_q  <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cap_wen_q  <= cap_wen_d;
         cap_mode_q <= cap_mode_d;
         cap_addr_q <= cap_addr_d;
         cap_dat_q  <= cap_dat_d;
         ready_q    <= ready_d;
      end
   end

   assign bus_ready = ready_q;
   assign acc_en    = (state_q == RESP);
   assign acc_wen   = cap_wen_q;
   assign acc_mode  = cap_mode_q;
   assign acc_addr  = cap_addr_q;
   assign acc_dat   = cap_dat_q;

endmodule
`default_nettype wire

// File: rtl/uibi_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uibi_timer
// UIBI machine timer: 64-bit mtime/mtimecmp with level timer interrupt.
// Optional prescaler enabled by defining UIBI_TIMER_PRESCALE_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uibi_timer
   import uibi_pkg::*;
#(
   parameter int               XLEN    = 32,
   parameter int               NUM_W   = 4,
   parameter logic [NUM_W-1:0] DEV_ID  = 4'd1,
   parameter int               PRESC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bus_req,
   input  logic             bus_wen,
   input  logic [2:0]       bus_mode,
   input  logic [XLEN-1:0]  bus_addr,
   input  logic [NUM_W-1:0] bus_num,
   input  logic [XLEN-1:0]  bus_dat_w,
   output logic [XLEN-1:0]  bus_dat_r,
   output logic             bus_ready,
   output logic             intr
);

   logic            acc_en;
   logic            acc_wen;
   logic [2:0]      acc_mode;
   logic [XLEN-1:0] acc_addr;
   logic [XLEN-1:0] acc_dat;

   uibi_slave_if #(
      .XLEN   (XLEN),
      .NUM_W  (NUM_W),
      .DEV_ID (DEV_ID)
   ) u_slave_if (
      .clk       (clk),
      .rst       (rst),
      .bus_req   (bus_req),
      .bus_wen   (bus_wen),
      .bus_mode  (bus_mode),
      .bus_addr  (bus_addr),
      .bus_num   (bus_num),
      .bus_dat_w (bus_dat_w),
      .bus_ready (bus_ready),
      .acc_en    (acc_en),
      .acc_wen   (acc_wen),
      .acc_mode  (acc_mode),
      .acc_addr  (acc_addr),
      .acc_dat   (acc_dat)
   );

   logic [2:0] acc_off;
   logic       wr_word;
   logic       rd_acc;
   logic       unused_addr_bits;

   assign acc_off          = acc_addr[4:2];
   assign wr_word          = acc_en && acc_wen && is_word(acc_mode);
   assign rd_acc           = acc_en && !acc_wen;
   assign unused_addr_bits = ^{acc_addr[XLEN-1:5], acc_addr[1:0]};

   logic [63:0]     mtime_q, mtime_d;
   logic [63:0]     mtimecmp_q, mtimecmp_d;
   logic            en_q, en_d;
   logic            ie_q, ie_d;
   logic            intr_q, intr_d;
   logic [XLEN-1:0] dat_r_q, dat_r_d;
   logic [XLEN-1:0] rd_word;
   logic            tick;
   logic [PRESC_W-1:0] presc_rd;

`ifdef UIBI_TIMER_PRESCALE_EN
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] pcnt_q, pcnt_d;

   always_comb begin
      presc_d = presc_q;
      pcnt_d  = pcnt_q;
      tick    = 1'b0;
      if (en_q) begin
         if (pcnt_q == presc_q) begin
            tick   = 1'b1;
            pcnt_d = '0;
         end else begin
            pcnt_d = pcnt_q + 1'b1;
         end
      end
      if (wr_word && (acc_off == OFF_PRESC)) begin
         presc_d = acc_dat[PRESC_W-1:0];
         pcnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         pcnt_q  <= '0;
      end else begin
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
      end
   end

   assign presc_rd = presc_q;
`else
   assign tick     = en_q;
   assign presc_rd = '0;
`endif

   always_comb begin
      rd_word = '0;
      case (acc_off)
         OFF_MTIME_LO:    rd_word = mtime_q[31:0];
         OFF_MTIME_HI:    rd_word = mtime_q[63:32];
         OFF_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
         OFF_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
         OFF_CTRL: begin
            rd_word[CTRL_EN_BIT] = en_q;
            rd_word[CTRL_IE_BIT] = ie_q;
         end
         OFF_PRESC:       rd_word = {{(XLEN-PRESC_W){1'b0}}, presc_rd};
         default:         rd_word = '0;
      endcase
   end

   always_comb begin
      mtimecmp_d = mtimecmp_q;
      en_d       = en_q;
      ie_d       = ie_q;
      dat_r_d    = dat_r_q;
      intr_d     = ie_q && (mtime_q >= mtimecmp_q);
      mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
      // A software write to either mtime half replaces this cycle's increment.
      if (wr_word) begin
         case (acc_off)
            OFF_MTIME_LO:    mtime_d    = {mtime_q[63:32], acc_dat};
            OFF_MTIME_HI:    mtime_d    = {acc_dat, mtime_q[31:0]};
            OFF_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], acc_dat};
            OFF_MTIMECMP_HI: mtimecmp_d = {acc_dat, mtimecmp_q[31:0]};
            OFF_CTRL: begin
               en_d = acc_dat[CTRL_EN_BIT];
               ie_d = acc_dat[CTRL_IE_BIT];
            end
            default: ;
         endcase
      end
      if (rd_acc) dat_r_d = rd_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         en_q       <= 1'b0;
         ie_q       <= 1'b0;
         intr_q     <= 1'b0;
         dat_r_q    <= '0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         en_q       <= en_d;
         ie_q       <= ie_d;
         intr_q     <= intr_d;
         dat_r_q    <= dat_r_d;
      end
   end

   assign bus_dat_r = dat_r_q;
   assign intr      = intr_q;

endmodule
`default_nettype wire

// File: tb/tb_uibi_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uibi_timer
// Randomized self-checking bench for uibi_timer against a behavioural model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uibi_timer;

   localparam logic [3:0] DEV = 4'd1;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_req;
   logic        bus_wen;
   logic [2:0]  bus_mode;
   logic [31:0] bus_addr;
   logic [3:0]  bus_num;
   logic [31:0] bus_dat_w;
   logic [31:0] bus_dat_r;
   logic        bus_ready;
   logic        intr;

   uibi_timer #(
      .XLEN    (32),
      .NUM_W   (4),
      .DEV_ID  (DEV),
      .PRESC_W (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus_req   (bus_req),
      .bus_wen   (bus_wen),
      .bus_mode  (bus_mode),
      .bus_addr  (bus_addr),
      .bus_num   (bus_num),
      .bus_dat_w (bus_dat_w),
      .bus_dat_r (bus_dat_r),
      .bus_ready (bus_ready),
      .intr      (intr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Behavioural model of the timer's architectural state.
   logic [63:0] m_time, m_cmp;
   bit          m_en, m_ie, m_intr;
   int unsigned m_presc, m_pcnt;
   logic [31:0] m_rdat;

   // Bus operation scheduled to complete at the next clock edge.
   bit          p_valid = 1'b0;
   bit          p_wen, p_word;
   int          p_off;
   logic [31:0] p_dat;

   function automatic logic [31:0] model_read(input int off);
      case (off)
         0: return m_time[31:0];
         1: return m_time[63:32];
         2: return m_cmp[31:0];
         3: return m_cmp[63:32];
         4: return {30'd0, m_ie, m_en};
`ifdef UIBI_TIMER_PRESCALE_EN
         5: return m_presc;
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge();
      bit          do_tick, new_intr, time_written;
      logic [63:0] t;
      if (rst) begin
         m_time = 64'd0; m_cmp = '1; m_en = 0; m_ie = 0; m_intr = 0;
         m_presc = 0; m_pcnt = 0; m_rdat = 32'd0;
         return;
      end
`ifdef UIBI_TIMER_PRESCALE_EN
      do_tick = m_en && (m_pcnt == m_presc);
      if (m_en) m_pcnt = (m_pcnt == m_presc) ? 0 : m_pcnt + 1;
`else
      do_tick = m_en;
`endif
      new_intr     = m_ie && (m_time >= m_cmp);
      time_written = 1'b0;
      t            = m_time;
      if (p_valid && !p_wen) m_rdat = model_read(p_off);
      if (p_valid && p_wen && p_word) begin
         case (p_off)
            0: begin t[31:0]  = p_dat; time_written = 1'b1; end
            1: begin t[63:32] = p_dat; time_written = 1'b1; end
            2: m_cmp[31:0]  = p_dat;
            3: m_cmp[63:32] = p_dat;
            4: begin m_en = p_dat[0]; m_ie = p_dat[1]; end
`ifdef UIBI_TIMER_PRESCALE_EN
            5: begin m_presc = p_dat[15:0]; m_pcnt = 0; end
`endif
            default: ;
         endcase
      end
      m_time = time_written ? t : (do_tick ? m_time + 64'd1 : m_time);
      m_intr = new_intr;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      p_valid = 1'b0;
      #1;
      check_eq("intr", intr, m_intr);
   endtask

   task automatic drive_req(input bit wen, input logic [2:0] mode, input int off,
                            input logic [31:0] dat, input logic [3:0] num);
      logic [31:0] a;
      a        = $urandom;
      a[4:2]   = off[2:0];
      if (mode == 3'b010) a[1:0] = 2'b00;
      bus_req   = 1'b1;
      bus_wen   = wen;
      bus_mode  = mode;
      bus_addr  = a;
      bus_num   = num;
      bus_dat_w = dat;
   endtask

   task automatic release_req();
      bus_req   = 1'b0;
      bus_wen   = $urandom_range(0, 1);
      bus_dat_w = $urandom;
   endtask

   task automatic xfer(input bit wen, input logic [2:0] mode, input int off,
                       input logic [31:0] dat, input int hold);
      drive_req(wen, mode, off, dat, DEV);
      step();
      check_eq("rdy_early", bus_ready, 1'b0);
      p_valid = 1'b1; p_wen = wen; p_word = (mode == 3'b010); p_off = off; p_dat = dat;
      step();
      check_eq("rdy_pulse", bus_ready, 1'b1);
      if (!wen) check_eq($sformatf("rdata_off%0d", off), bus_dat_r, m_rdat);
      for (int i = 0; i < hold; i++) begin
         step();
         check_eq("rdy_hold", bus_ready, 1'b0);
      end
      release_req();
      step();
      check_eq("rdy_after", bus_ready, 1'b0);
   endtask

   task automatic wr(input int off, input logic [31:0] dat);
      xfer(1'b1, 3'b010, off, dat, 0);
   endtask

   task automatic rd(input int off);
      xfer(1'b0, 3'b010, off, 32'd0, 0);
   endtask

   initial begin
      logic [2:0] sub_modes [4];
      int         bound;
      sub_modes = '{3'b000, 3'b001, 3'b100, 3'b101};
      rst = 1'b1; bus_req = 1'b0; bus_wen = 1'b0; bus_mode = 3'b010;
      bus_addr = 32'd0; bus_num = 4'd0; bus_dat_w = 32'd0;

      repeat (3) step();
      rst = 1'b0;
      check_eq("rst_ready", bus_ready, 1'b0);
      check_eq("rst_dat_r", bus_dat_r, 32'd0);
      check_eq("rst_intr", intr, 1'b0);
      step();

      rd(2);
      check_eq("cmp_lo_rst", bus_dat_r, 32'hFFFF_FFFF);
      rd(4);

      // Free-running count
      wr(4, 32'd1);
      repeat (10) step();
      rd(0);
      rd(1);

      // Carry from LO into HI
      wr(4, 32'd0);
      wr(0, 32'hFFFF_FFFE);
      wr(1, 32'd0);
      wr(4, 32'd1);
      rd(1);
      rd(0);

      // 64-bit wrap
      wr(4, 32'd0);
      wr(0, 32'hFFFF_FFFF);
      wr(1, 32'hFFFF_FFFF);
      wr(4, 32'd1);
      rd(0);
      rd(1);

      // Interrupt rise and clear
      wr(4, 32'd0);
      wr(0, 32'd0);
      wr(1, 32'd0);
      wr(3, 32'd0);
      wr(2, 32'd100);
      wr(4, 32'd3);
      bound = 0;
      while (!m_intr && bound < 400) begin step(); bound++; end
      check_eq("intr_rise_bound", bound < 400, 1'b1);
      repeat (3) step();
      wr(2, 32'd1000);
      repeat (2) step();
      check_eq("intr_cleared", intr, 1'b0);

      // Held request executes once
      xfer(1'b1, 3'b010, 0, 32'd5, 8);
      rd(0);

      // Other device select is ignored
      drive_req(1'b1, 3'b010, 4, 32'd0, 4'd7);
      repeat (5) begin
         step();
         check_eq("foreign_rdy", bus_ready, 1'b0);
      end
      release_req();
      step();
      rd(4);

      // Byte write to CTRL is acknowledged but ignored
      xfer(1'b1, 3'b000, 4, 32'd0, 0);
      rd(4);

`ifdef UIBI_TIMER_PRESCALE_EN
      wr(4, 32'd0);
      wr(0, 32'd0);
      wr(5, 32'd3);
      wr(4, 32'd1);
      repeat (12) step();
      rd(0);
      rd(5);
`else
      wr(5, 32'd3);
      rd(5);
      check_eq("presc_reserved", bus_dat_r, 32'd0);
`endif

      // Reset during RESP
      wr(2, 32'd50);
      drive_req(1'b1, 3'b010, 4, 32'd3, DEV);
      step();
      rst = 1'b1;
      p_valid = 1'b1; p_wen = 1'b1; p_word = 1'b1; p_off = 4; p_dat = 32'd3;
      step();
      check_eq("rst_mid_rdy", bus_ready, 1'b0);
      check_eq("rst_mid_dat", bus_dat_r, 32'd0);
      rst = 1'b0;
      release_req();
      step();
      check_eq("rst_mid_rdy2", bus_ready, 1'b0);
      rd(2);
      rd(3);
      rd(4);
      rd(0);

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         int          off;
         bit          wen;
         logic [2:0]  mode;
         logic [31:0] dat;
         repeat ($urandom_range(0, 3)) step();
         off  = $urandom_range(0, 7);
         wen  = $urandom_range(0, 1);
         mode = ($urandom_range(0, 4) == 0) ? sub_modes[$urandom_range(0, 3)] : 3'b010;
         dat  = $urandom;
         if (off == 5) dat = $urandom_range(0, 4);
         if ((off == 2 || off == 0) && $urandom_range(0, 1) == 1) dat = $urandom_range(0, 60);
         if (off == 1 || off == 3) dat = $urandom_range(0, 1) ? 32'd0 : dat;
         xfer(wen, mode, off, dat, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
